// File: rtl/hazard_control_unit.sv
// hazard_control_unit: load-use/branch hazard stall FSM with IF/ID flush and debug halt.
// Optional saturating stall/flush performance counters under `HDU_PERF_CNT_EN.
module hazard_control_unit #(
  parameter int REG_ADDR_W        = 5,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_id_ex_memread,
  input  logic                  i_id_ex_regwrite,
  input  logic [REG_ADDR_W-1:0] i_id_ex_rt,
  input  logic [REG_ADDR_W-1:0] i_ex_rd,
  input  logic                  i_ex_mem_memread,
  input  logic [REG_ADDR_W-1:0] i_ex_mem_rd,
  input  logic [REG_ADDR_W-1:0] i_if_id_rs,
  input  logic [REG_ADDR_W-1:0] i_if_id_rt,
  input  logic                  i_if_id_uses_rt,
  input  logic [1:0]            i_jumptype,
  input  logic                  i_branch_taken,
  input  logic                  i_halt,
  output logic                  o_pc_write,
  output logic                  o_if_id_write,
  output logic                  o_ctrl_to_zero,
  output logic                  o_if_id_flush,
  output logic                  o_stall,
  output logic [CNT_W-1:0]      o_stall_count,
  output logic [CNT_W-1:0]      o_flush_count
);
  typedef enum logic [1:0] {RUN, STALL, HALT} state_t;
  localparam logic [2:0] LS  = 3'(LOAD_STALL_CYCLES);
  localparam logic [2:0] LS1 = 3'(LOAD_STALL_CYCLES + 1);
  state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d, n;
  logic br, rt_ok, ex_load, ex_alu, mem_load, flush_req, stall, frozen, flush;
  function automatic logic hit(input logic [REG_ADDR_W-1:0] s, input logic [REG_ADDR_W-1:0] d);
    return s != '0 && s == d;
  endfunction
  assign br        = i_jumptype == 2'b01 || i_jumptype == 2'b10;
  assign rt_ok     = i_if_id_uses_rt && i_jumptype != 2'b10;
  assign ex_load   = i_id_ex_memread && (hit(i_if_id_rs, i_id_ex_rt) || (rt_ok && hit(i_if_id_rt, i_id_ex_rt)));
  assign ex_alu    = i_id_ex_regwrite && (hit(i_if_id_rs, i_ex_rd) || (rt_ok && hit(i_if_id_rt, i_ex_rd)));
  assign mem_load  = i_ex_mem_memread && (hit(i_if_id_rs, i_ex_mem_rd) || (rt_ok && hit(i_if_id_rt, i_ex_mem_rd)));
  assign n         = br && ex_load ? LS1 : ex_load ? LS : br && (ex_alu || mem_load) ? 3'd1 : 3'd0;
  assign flush_req = i_jumptype[1] || (i_jumptype == 2'b01 && i_branch_taken);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    frozen  = 1'b0;
    flush   = 1'b0;
    case (state_q)
      RUN: begin
        if (i_halt) begin
          frozen  = 1'b1;
          state_d = HALT;
        end else if (n != 3'd0) begin
          stall = 1'b1;
          if (n > 3'd1) begin
            state_d = STALL;
            cnt_d   = n - 3'd1;
          end
        end else flush = flush_req;
      end
      STALL: begin
        stall   = 1'b1;
        cnt_d   = cnt_q - 3'd1;
        state_d = cnt_q == 3'd1 ? RUN : STALL;
      end
      HALT: begin
        frozen  = 1'b1;
        state_d = i_halt ? HALT : RUN;
      end
      default: state_d = RUN;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= RUN;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  assign o_pc_write     = !i_reset && !stall && !frozen;
  assign o_if_id_write  = o_pc_write;
  assign o_ctrl_to_zero = i_reset || stall || frozen;
  assign o_if_id_flush  = !i_reset && flush;
  assign o_stall        = !i_reset && stall;
`ifdef HDU_PERF_CNT_EN
  logic [CNT_W-1:0] stall_count_q, stall_count_d, flush_count_q, flush_count_d;
  always_comb begin
    stall_count_d = stall_count_q + CNT_W'(o_stall && !(&stall_count_q));
    flush_count_d = flush_count_q + CNT_W'(o_if_id_flush && !(&flush_count_q));
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end
  assign o_stall_count = stall_count_q;
  assign o_flush_count = flush_count_q;
`else
  assign o_stall_count = '0;
  assign o_flush_count = '0;
`endif
endmodule

// File: doc/hazard_control_unit.md
# hazard_control_unit

Parametrised pipeline hazard controller for the MIPS core, between IF/ID and ID/EX. Detects load-use and branch-operand hazards, stalls the front end for a configurable number of cycles through a small state machine, flushes IF/ID on taken control transfers, and supports an external halt. It replaces the purely combinational load-use stall with a registered multi-cycle stall and a flush/halt path.

## Interface
- `REG_ADDR_W`, 5, register-number width
- `LOAD_STALL_CYCLES`, 1, stall cycles for a load-use hazard (legal 1..6)
- `CNT_W`, 16, width of the performance counters
- `i_clk`  in  1  clock; all state updates on rising edge
- `i_reset`  in  1  reset, synchronous and active-high
- `i_id_ex_memread`  in  1  instruction in EX is a load
- `i_id_ex_regwrite`  in  1  instruction in EX writes a register
- `i_id_ex_rt`  in  REG_ADDR_W  load destination in EX
- `i_ex_rd`  in  REG_ADDR_W  resolved destination of the instruction in EX
- `i_ex_mem_memread`  in  1  instruction in MEM is a load
- `i_ex_mem_rd`  in  REG_ADDR_W  destination of the instruction in MEM
- `i_if_id_rs`, `i_if_id_rt`  in  REG_ADDR_W  sources of the instruction in ID
- `i_if_id_uses_rt`  in  1  ID instruction reads rt
- `i_jumptype`  in  2  00 none, 01 beq/bne, 10 jr/jalr, 11 j/jal
- `i_branch_taken`  in  1  ID comparator result (valid when jumptype=01)
- `i_halt`  in  1  freeze request from the debug unit
- `o_pc_write`  out  1  PC update enable
- `o_if_id_write`  out  1  IF/ID update enable
- `o_ctrl_to_zero`  out  1  inject a bubble into ID/EX
- `o_if_id_flush`  out  1  clear IF/ID
- `o_stall`  out  1  a stall is in progress
- `o_stall_count`, `o_flush_count`  out  CNT_W  performance counters

## Operation
- A source matches when it is nonzero and equals the destination. rt is considered only if `i_if_id_uses_rt` is high, and never for jumptype=10.
- Hazard length N:
  - Jumptype 01/10 with an EX load match (`i_id_ex_memread`, `i_id_ex_rt`): N = LOAD_STALL_CYCLES+1.
  - Any jumptype with an EX load match: N = LOAD_STALL_CYCLES.
  - Jumptype 01/10 with an EX ALU match (`i_id_ex_regwrite`, `i_ex_rd`): N = 1.
  - Jumptype 01/10 with a MEM load match: N = 1.
  - Otherwise N = 0. When several rules apply, the first matching rule in this order wins.
- FSM states: RUN, STALL, HALT. A 3-bit down-counter `cnt`.
- RUN:
  - If `i_halt`, go to HALT.
  - Else if N>0: stall this cycle. If N>1, go to STALL with cnt=N-1.
  - Else, if jumptype=11, jumptype=10, or (jumptype=01 and `i_branch_taken`): flush this cycle.
- STALL: stall every cycle and decrement cnt. When cnt==1, go to RUN. Hazard inputs are ignored, and `i_halt` is deferred until RUN.
- HALT: frozen. When `i_halt` is low, go to RUN.
- Output decode:
  - Stall: pc_write=0, if_id_write=0, ctrl_to_zero=1, o_stall=1, flush=0.
  - Frozen: pc_write=0, if_id_write=0, ctrl_to_zero=1, o_stall=0.
  - Flush: pc_write=1, if_id_write=1, flush=1.
  - Idle: pc_write=1, if_id_write=1, everything else 0.
- Priority: reset > halt > stall > flush. A stall always suppresses the flush; the branch is re-evaluated once the stall ends.

## Timing
- Outputs are combinational from the current state and the inputs. Zero-latency response in RUN.
- Total stall per hazard is exactly N cycles: 1 cycle in RUN plus N-1 cycles in STALL.
- During `i_reset` high: state=RUN, cnt=0, counters=0, pc_write=0, if_id_write=0, ctrl_to_zero=1, flush=0, o_stall=0.
- Reset while in STALL or HALT returns to RUN on the next edge.
- HALT is entered on the edge after `i_halt` is seen in RUN, and exits on the edge after it drops.

## Configuration
- `HDU_PERF_CNT_EN` defined:
  - `o_stall_count` increments on every cycle with o_stall=1.
  - `o_flush_count` increments on every cycle with flush=1.
  - Both counters saturate at all-ones and clear on reset.
- `HDU_PERF_CNT_EN` undefined: both ports are tied to 0 and no counter registers exist.

## Test plan
- LOAD_STALL_CYCLES=1. EX load with rt=8, ID rs=8 -> o_stall high for 1 cycle, then a same-cycle return to idle outputs; with perf counters enabled, stall_count=1.
- LOAD_STALL_CYCLES=3. Same stimulus -> 3 stall cycles (RUN, STALL cnt=2, cnt=1); hazard inputs changed mid-stall are ignored.
- beq in ID with rs=5, EX load rt=5, LOAD_STALL_CYCLES=1 -> 2 stall cycles. Then with `i_branch_taken`=1 and the hazard cleared -> a 1-cycle flush.
- Load to r0 with ID rs=0 -> no stall. j (jumptype=11) -> flush=1, pc_write=1.
- `i_halt` asserted during a 3-cycle stall -> stall completes, then HALT with all writes 0. Deassert -> RUN the next cycle.
- Reset asserted in STALL -> reset outputs that cycle, then RUN and idle outputs; counters are 0.
